// File: rtl/ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl
// Front-end hazard controller for the IF/ID boundary of a 5-stage pipeline.
// A small registered state (RUN / LDSTALL / FLUSH / HOLD) remembers what
// happened last cycle. All control outputs are combinational from that state
// and the current hazard inputs.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   id_rs, id_rt         source fields of the instruction in IF/ID
//   id_uses_rt           IF/ID instruction actually reads rt
//   ex_rd, ex_load       destination / load flag of the instruction in EX
//   branch_taken, jump   redirect requests resolved in ID
//   ext_hold             memory busy: freeze the front end
//   pc_le, ifid_le       PC and IF/ID load enables
//   ifid_flush           IF/ID captures a NOP instead of the fetched word
//   idex_nop             ID/EX control forced to zero (bubble)
//   pc_sel               00 PC+4, 01 branch target, 10 jump target
//   state_o              current state (RUN=0, LDSTALL=1, FLUSH=2, HOLD=3)
//   stall_cycles         cycles with pc_le=0 (saturating)
//   flush_count          cycles with ifid_flush=1 (saturating)
//
// Build option: define HAZ_STATS_EN to build the two statistics counters.
// Without it the counter ports are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module ifid_hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_load,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        ext_hold,
   output logic        pc_le,
   output logic        ifid_le,
   output logic        ifid_flush,
   output logic        idex_nop,
   output logic [1:0]  pc_sel,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   load_use;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = ex_load & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

   always_comb begin
      state_d    = RUN;
      pc_le      = 1'b1;
      ifid_le    = 1'b1;
      ifid_flush = 1'b0;
      idex_nop   = 1'b0;
      pc_sel     = 2'b00;
      if (reset) begin
         pc_le    = 1'b0;
         ifid_le  = 1'b0;
         idex_nop = 1'b1;
      end else if (ext_hold) begin
         // Freeze applies in every state. ID is held too, so EX gets a bubble
         // rather than a second copy of the held instruction.
         pc_le    = 1'b0;
         ifid_le  = 1'b0;
         idex_nop = 1'b1;
         state_d  = HOLD;
      end else if (state_q == FLUSH) begin
         // ID holds the squashed NOP: its redirect/hazard inputs are stale.
         state_d = RUN;
      end else if (load_use && (state_q != LDSTALL)) begin
         // The load has moved on after one stall cycle, so a repeated match
         // in LDSTALL is the same hazard and must not stall again.
         pc_le    = 1'b0;
         ifid_le  = 1'b0;
         idex_nop = 1'b1;
         state_d  = LDSTALL;
      end else if (jump) begin
         pc_sel     = 2'b10;
         ifid_flush = 1'b1;
         state_d    = FLUSH;
      end else if (branch_taken) begin
         pc_sel     = 2'b01;
         ifid_flush = 1'b1;
         state_d    = FLUSH;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   assign state_o = state_q;

`ifdef HAZ_STATS_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q,  flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_le && (stall_cycles_q != 16'hFFFF))
         stall_cycles_d = stall_cycles_q + 16'd1;
      if (ifid_flush && (flush_count_q != 16'hFFFF))
         flush_count_d = flush_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= 16'd0;
         flush_count_q  <= 16'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 16'd0;
   assign flush_count  = 16'd0;
`endif

endmodule
